// File: rtl/mem_arbiter_2to1_if.sv
// Mem_ift: one requester-to-memory link. Request fields flow Master->Slave,
// the read data and the read/write completion strobes flow back.
interface Mem_ift #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]   mr_raddr;
  logic                    mr_ren;
  logic [ADDR_WIDTH-1:0]   mw_waddr;
  logic                    mw_wen;
  logic [DATA_WIDTH-1:0]   mw_wdata;
  logic [DATA_WIDTH/8-1:0] mw_wmask;
  logic [DATA_WIDTH-1:0]   sr_rdata;
  logic                    sr_rvalid;
  logic                    sw_wvalid;

  modport Master (
    output mr_raddr, mr_ren, mw_waddr, mw_wen, mw_wdata, mw_wmask,
    input  sr_rdata, sr_rvalid, sw_wvalid
  );

  modport Slave (
    input  mr_raddr, mr_ren, mw_waddr, mw_wen, mw_wdata, mw_wmask,
    output sr_rdata, sr_rvalid, sw_wvalid
  );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// 2:1 arbiter sharing one memory port between instruction fetch (port 0) and
// data access (port 1). Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data-port priority.
module mem_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128
) (
  input  logic   clk,
  input  logic   rstn,
  Mem_ift.Slave  if_ift,
  Mem_ift.Slave  d_ift,
  Mem_ift.Master mem_ift,
  output logic   busy,
  output logic   grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e state_q;
  logic   busy_q;
  logic   grant_id_q;

  logic req_i, req_d, done, win_dat, own_i, own_d;

  logic [ADDR_WIDTH-1:0]   raddr_sel, waddr_sel;
  logic                    ren_sel, wen_sel;
  logic [DATA_WIDTH-1:0]   wdata_sel;
  logic [DATA_WIDTH/8-1:0] wmask_sel;

  assign req_i = if_ift.mr_ren | if_ift.mw_wen;
  assign req_d = d_ift.mr_ren | d_ift.mw_wen;
  assign done  = mem_ift.sr_rvalid | mem_ift.sw_wvalid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  // On a tie the port that did not win the previous grant goes first.
  assign win_dat = req_d & (~req_i | ~last_grant_q);
`else
  assign win_dat = req_d;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      grant_id_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i | req_d) begin
            state_q    <= win_dat ? GNT_D : GNT_I;
            busy_q     <= 1'b1;
            grant_id_q <= win_dat;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= win_dat;
`endif
          end
        end
        GNT_I, GNT_D: begin
          // Completion always drops to IDLE for one cycle so the slave sees a fresh request edge.
          if (done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign own_i = (state_q == GNT_I);
  assign own_d = (state_q == GNT_D);

  always_comb begin
    raddr_sel = '0;
    ren_sel   = 1'b0;
    waddr_sel = '0;
    wen_sel   = 1'b0;
    wdata_sel = '0;
    wmask_sel = '0;
    if (own_i) begin
      raddr_sel = if_ift.mr_raddr;
      ren_sel   = if_ift.mr_ren;
      waddr_sel = if_ift.mw_waddr;
      wen_sel   = if_ift.mw_wen;
      wdata_sel = if_ift.mw_wdata;
      wmask_sel = if_ift.mw_wmask;
    end else if (own_d) begin
      raddr_sel = d_ift.mr_raddr;
      ren_sel   = d_ift.mr_ren;
      waddr_sel = d_ift.mw_waddr;
      wen_sel   = d_ift.mw_wen;
      wdata_sel = d_ift.mw_wdata;
      wmask_sel = d_ift.mw_wmask;
    end
  end

  assign mem_ift.mr_raddr = raddr_sel;
  assign mem_ift.mr_ren   = ren_sel;
  assign mem_ift.mw_waddr = waddr_sel;
  assign mem_ift.mw_wen   = wen_sel;
  assign mem_ift.mw_wdata = wdata_sel;
  assign mem_ift.mw_wmask = wmask_sel;

  // Read data is broadcast; only the strobes are steered to the owner.
  assign if_ift.sr_rdata  = mem_ift.sr_rdata;
  assign d_ift.sr_rdata   = mem_ift.sr_rdata;
  assign if_ift.sr_rvalid = own_i & mem_ift.sr_rvalid;
  assign if_ift.sw_wvalid = own_i & mem_ift.sw_wvalid;
  assign d_ift.sr_rvalid  = own_d & mem_ift.sr_rvalid;
  assign d_ift.sw_wvalid  = own_d & mem_ift.sw_wvalid;

  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Bench for mem_arbiter_2to1: directed scenarios then random traffic, every cycle
// compared against a transaction-level owner/priority model.
module tb_mem_arbiter_2to1;
  localparam int AW = 64;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy, grant_id;
  always #5 clk = ~clk;

  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();
  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dfb ();
  Mem_ift #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mfb ();

  mem_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .if_ift(ifb), .d_ift(dfb), .mem_ift(mfb),
    .busy(busy), .grant_id(grant_id)
  );

  int nvec = 0;
  int nerr = 0;
  int owner = -1;   // -1 none, 0 instruction port, 1 data port
`ifdef ARB_ROUND_ROBIN_EN
  bit last_g = 1'b1;
`endif
  bit seen_i, seen_d;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    ifb.mr_ren = 0; ifb.mw_wen = 0; ifb.mr_raddr = '0; ifb.mw_waddr = '0;
    ifb.mw_wdata = '0; ifb.mw_wmask = '0;
    dfb.mr_ren = 0; dfb.mw_wen = 0; dfb.mr_raddr = '0; dfb.mw_waddr = '0;
    dfb.mw_wdata = '0; dfb.mw_wmask = '0;
    mfb.sr_rvalid = 0; mfb.sw_wvalid = 0; mfb.sr_rdata = '0;
  endtask

  // Expected outputs follow from who owns the port and what the TB is driving.
  task automatic check_outputs();
    logic [AW-1:0] e_raddr, e_waddr;
    logic e_ren, e_wen;
    logic [DW-1:0] e_wdata;
    logic [DW/8-1:0] e_wmask;
    e_raddr = '0; e_waddr = '0; e_ren = 0; e_wen = 0; e_wdata = '0; e_wmask = '0;
    if (owner == 0) begin
      e_raddr = ifb.mr_raddr; e_ren = ifb.mr_ren; e_waddr = ifb.mw_waddr;
      e_wen = ifb.mw_wen; e_wdata = ifb.mw_wdata; e_wmask = ifb.mw_wmask;
    end else if (owner == 1) begin
      e_raddr = dfb.mr_raddr; e_ren = dfb.mr_ren; e_waddr = dfb.mw_waddr;
      e_wen = dfb.mw_wen; e_wdata = dfb.mw_wdata; e_wmask = dfb.mw_wmask;
    end
    chk("busy", busy, owner >= 0);
    if (owner >= 0) chk("grant_id", grant_id, owner == 1);
    chk("mem_ren", mfb.mr_ren, e_ren);
    chk("mem_wen", mfb.mw_wen, e_wen);
    chk("mem_raddr", mfb.mr_raddr, e_raddr);
    chk("mem_waddr", mfb.mw_waddr, e_waddr);
    chk("mem_wdata", mfb.mw_wdata, e_wdata);
    chk("mem_wmask", mfb.mw_wmask, e_wmask);
    chk("if_rvalid", ifb.sr_rvalid, owner == 0 && mfb.sr_rvalid);
    chk("if_wvalid", ifb.sw_wvalid, owner == 0 && mfb.sw_wvalid);
    chk("d_rvalid", dfb.sr_rvalid, owner == 1 && mfb.sr_rvalid);
    chk("d_wvalid", dfb.sw_wvalid, owner == 1 && mfb.sw_wvalid);
    chk("if_rdata", ifb.sr_rdata, mfb.sr_rdata);
    chk("d_rdata", dfb.sr_rdata, mfb.sr_rdata);
  endtask

  task automatic update_model();
    bit ri, rd;
    int win;
    ri = ifb.mr_ren | ifb.mw_wen;
    rd = dfb.mr_ren | dfb.mw_wen;
    if (!rstn) begin
      owner = -1;
`ifdef ARB_ROUND_ROBIN_EN
      last_g = 1'b1;
`endif
    end else if (owner < 0) begin
      if (ri || rd) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = (ri && rd) ? (last_g ? 0 : 1) : (rd ? 1 : 0);
        last_g = (win == 1);
`else
        win = rd ? 1 : 0;
`endif
        owner = win;
      end
    end else if (mfb.sr_rvalid || mfb.sw_wvalid) begin
      owner = -1;
    end
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    seen_i = ifb.sr_rvalid | ifb.sw_wvalid;
    seen_d = dfb.sr_rvalid | dfb.sw_wvalid;
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bit pend_i, pend_d;
    int kind;
    logic exp_g;
    idle_all();
    rstn = 0;
    step(); step();
    settle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_mem_ren", mfb.mr_ren, 1'b0);
    chk("rst_mem_wen", mfb.mw_wen, 1'b0);
    chk("rst_if_rvalid", ifb.sr_rvalid, 1'b0);
    chk("rst_d_wvalid", dfb.sw_wvalid, 1'b0);
    rstn = 1;
    step();

    // Single fetch, answered in the third granted cycle.
    ifb.mr_ren = 1; ifb.mr_raddr = 64'h1000;
    settle(); chk("sf_T_busy", busy, 1'b0);
    step();
    settle();
    chk("sf_T1_ren", mfb.mr_ren, 1'b1);
    chk("sf_T1_raddr", mfb.mr_raddr, 64'h1000);
    chk("sf_T1_gid", grant_id, 1'b0);
    step();
    step();
    mfb.sr_rvalid = 1; mfb.sr_rdata = {16{8'hAA}};
    settle();
    chk("sf_T3_if_rvalid", ifb.sr_rvalid, 1'b1);
    chk("sf_T3_rdata", ifb.sr_rdata, {16{8'hAA}});
    chk("sf_T3_d_rvalid", dfb.sr_rvalid, 1'b0);
    step();
    idle_all(); settle();
    chk("sf_T4_busy", busy, 1'b0);
    chk("sf_T4_ren", mfb.mr_ren, 1'b0);
    step();

    // Simultaneous request: data port wins; fetch follows after the bubble.
    ifb.mr_ren = 1; ifb.mr_raddr = 64'h2000;
    dfb.mw_wen = 1; dfb.mw_waddr = 64'h3008; dfb.mw_wmask = 16'hFF00;
    dfb.mw_wdata = {$urandom, $urandom, $urandom, $urandom};
    step();
    mfb.sw_wvalid = 1;
    settle();
    chk("sim_gid", grant_id, 1'b1);
    chk("sim_waddr", mfb.mw_waddr, 64'h3008);
    chk("sim_wmask", mfb.mw_wmask, 16'hFF00);
    chk("sim_d_wvalid", dfb.sw_wvalid, 1'b1);
    chk("sim_if_wvalid", ifb.sw_wvalid, 1'b0);
    step();
    mfb.sw_wvalid = 0; dfb.mw_wen = 0;
    settle();
    chk("sim_R1_busy", busy, 1'b0);
    chk("sim_R1_ren", mfb.mr_ren, 1'b0);
    step();
    settle();
    chk("sim_R2_gid", grant_id, 1'b0);
    chk("sim_R2_raddr", mfb.mr_raddr, 64'h2000);
    mfb.sr_rvalid = 1;
    step();
    idle_all();

    // Both ports re-request continuously.
    ifb.mr_ren = 1; ifb.mr_raddr = 64'h4000;
    dfb.mr_ren = 1; dfb.mr_raddr = 64'h5000;
    for (int k = 0; k < 4; k++) begin
      settle(); chk("cont_idle_busy", busy, 1'b0);
      step();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0);
`else
      exp_g = 1'b1;
`endif
      settle(); chk("cont_gid", grant_id, exp_g);
      mfb.sr_rvalid = 1;
      step();
      mfb.sr_rvalid = 0;
    end
    dfb.mr_ren = 0;
    step();
    settle();
    chk("release_busy", busy, 1'b1);
    chk("release_gid", grant_id, 1'b0);
    mfb.sr_rvalid = 1;
    step();
    idle_all();
    step();

    // Reset while the data port holds the grant.
    dfb.mr_ren = 1; dfb.mr_raddr = 64'h6000;
    step();
    settle(); chk("rmid_gid", grant_id, 1'b1);
    rstn = 0;
    step();
    settle();
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_ren", mfb.mr_ren, 1'b0);
    rstn = 1; dfb.mr_ren = 0; mfb.sr_rvalid = 1;
    settle();
    chk("rmid_late_d", dfb.sr_rvalid, 1'b0);
    chk("rmid_late_i", ifb.sr_rvalid, 1'b0);
    step();
    mfb.sr_rvalid = 0;

    // Spurious response in IDLE.
    mfb.sr_rvalid = 1; mfb.sw_wvalid = 1;
    settle();
    chk("spur_if_rvalid", ifb.sr_rvalid, 1'b0);
    chk("spur_d_wvalid", dfb.sw_wvalid, 1'b0);
    step();
    idle_all(); settle();
    chk("spur_busy", busy, 1'b0);
    step();

    // Random traffic against the model.
    pend_i = 0; pend_d = 0; seen_i = 0; seen_d = 0;
    for (int c = 0; c < 2000; c++) begin
      if (pend_i && (seen_i || $urandom_range(0, 39) == 0)) begin
        pend_i = 0; ifb.mr_ren = 0; ifb.mw_wen = 0;
      end else if (!pend_i && $urandom_range(0, 3) == 0) begin
        pend_i = 1; kind = $urandom_range(0, 2);
        ifb.mr_ren = (kind != 1); ifb.mw_wen = (kind != 0);
        ifb.mr_raddr = {$urandom, $urandom}; ifb.mw_waddr = {$urandom, $urandom};
        ifb.mw_wdata = {$urandom, $urandom, $urandom, $urandom};
        ifb.mw_wmask = 16'($urandom);
      end
      if (pend_d && (seen_d || $urandom_range(0, 39) == 0)) begin
        pend_d = 0; dfb.mr_ren = 0; dfb.mw_wen = 0;
      end else if (!pend_d && $urandom_range(0, 3) == 0) begin
        pend_d = 1; kind = $urandom_range(0, 2);
        dfb.mr_ren = (kind != 1); dfb.mw_wen = (kind != 0);
        dfb.mr_raddr = {$urandom, $urandom}; dfb.mw_waddr = {$urandom, $urandom};
        dfb.mw_wdata = {$urandom, $urandom, $urandom, $urandom};
        dfb.mw_wmask = 16'($urandom);
      end
      mfb.sr_rvalid = ($urandom_range(0, 3) == 0);
      mfb.sw_wvalid = ($urandom_range(0, 5) == 0);
      mfb.sr_rdata  = {$urandom, $urandom, $urandom, $urandom};
      rstn = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
